// File: rtl/uart_byte_feeder.sv
// Byte FIFO feeding a bit-serial UART transmitter through its strobe/acknowledge handshake.
// Bytes are sent LSB first: optional clear_crc, start, 8 x (data + send), finish.
module uart_byte_feeder #(
  parameter int DEPTH              = 4,
  parameter int ACK_TIMEOUT        = 4096,
  parameter bit CLEAR_CRC_PER_BYTE = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  input  logic                     pause,
  input  logic                     err_clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     tx_send,
  output logic                     tx_data,
  output logic                     tx_finish,
  output logic                     tx_clear_crc,
  input  logic                     tx_acknowledge,
  output logic                     timeout_err,
  output logic                     overflow,
  output logic [15:0]              bytes_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ACK_TIMEOUT + 2) + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam int TO_LAST_I = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit TO_EN = (ACK_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_BIT_SETUP,
    S_BIT_SEND,
    S_FIN,
    S_WAIT
  } state_t;

  // Where WAIT returns to once the transmitter acknowledges.
  typedef enum logic [1:0] {
    RET_START,
    RET_BIT,
    RET_DONE
  } ret_t;

  state_t          state_q, state_d;
  ret_t            ret_q, ret_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_data_q, tx_data_d;
  logic [15:0]     bytes_sent_q, bytes_sent_d;
  logic            timeout_err_q, timeout_err_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic            full_w;
  logic            empty_w;
  logic            wr_accept;
  logic            pop;
  logic            ack_ok;
  logic            to_hit;
  logic            timeout_set;

  assign full_w    = (count_q == FULL_CNT);
  assign empty_w   = (count_q == '0);
  assign wr_accept = wr_en && !full_w;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    wait_cnt_d   = wait_cnt_q;
    idx_d        = idx_q;
    sh_d         = sh_q;
    tx_data_d    = tx_data_q;
    bytes_sent_d = bytes_sent_q;
    timeout_set  = 1'b0;
    pop          = 1'b0;
    // The first WAIT cycle (count 0) is the guard cycle: a stale acknowledge is ignored.
    ack_ok       = tx_acknowledge && (wait_cnt_q != '0);
    to_hit       = TO_EN && (wait_cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if (!empty_w && !pause) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          idx_d   = 3'd0;
          state_d = CLEAR_CRC_PER_BYTE ? S_CLEAR : S_START;
        end
      end
      S_CLEAR: state_d = S_START;
      S_START: begin
        state_d    = S_WAIT;
        ret_d      = RET_START;
        wait_cnt_d = '0;
      end
      S_BIT_SETUP: state_d = S_BIT_SEND;
      S_BIT_SEND: begin
        state_d    = S_WAIT;
        ret_d      = RET_BIT;
        wait_cnt_d = '0;
      end
      S_FIN: begin
        state_d    = S_WAIT;
        ret_d      = RET_DONE;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (ack_ok) begin
          case (ret_q)
            RET_START: state_d = S_BIT_SETUP;
            RET_BIT: begin
              idx_d   = idx_q + 3'd1;
              state_d = (idx_q == 3'd7) ? S_FIN : S_BIT_SETUP;
            end
            default: begin
              state_d      = S_IDLE;
              bytes_sent_d = bytes_sent_q + 16'd1;
            end
          endcase
        end else if (to_hit) begin
          state_d     = S_IDLE;
          timeout_set = 1'b1;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx_data only changes on entry to BIT_SETUP, so it is stable across the send and its wait.
    if (state_d == S_BIT_SETUP) begin
      tx_data_d = sh_q[idx_d];
    end
  end

  always_comb begin
    wr_ptr_d = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new error event outranks err_clear in the same cycle.
    overflow_d = overflow_q;
    if (wr_en && full_w) begin
      overflow_d = 1'b1;
    end else if (err_clear) begin
      overflow_d = 1'b0;
    end

    timeout_err_d = timeout_err_q;
    if (timeout_set) begin
      timeout_err_d = 1'b1;
    end else if (err_clear) begin
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ret_q         <= RET_START;
      wait_cnt_q    <= '0;
      idx_q         <= '0;
      tx_data_q     <= 1'b0;
      bytes_sent_q  <= '0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      wait_cnt_q    <= wait_cnt_d;
      idx_q         <= idx_d;
      tx_data_q     <= tx_data_d;
      bytes_sent_q  <= bytes_sent_d;
      timeout_err_q <= timeout_err_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clock) begin
    sh_q <= sh_d;
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full         = full_w;
  assign empty        = empty_w;
  assign level        = count_q;
  assign busy         = (state_q != S_IDLE);
  assign tx_send      = (state_q == S_START) || (state_q == S_BIT_SEND);
  assign tx_finish    = (state_q == S_FIN);
  assign tx_clear_crc = (state_q == S_CLEAR);
  assign tx_data      = tx_data_q;
  assign timeout_err  = timeout_err_q;
  assign overflow     = overflow_q;
  assign bytes_sent   = bytes_sent_q;

endmodule

// File: tb/tb_uart_byte_feeder.sv
// Directed bench for uart_byte_feeder: handshake framing, FIFO/overflow table, timeout and reset abort.
module tb_uart_byte_feeder;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        pause;
  logic        err_clear;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        busy;
  logic        tx_send;
  logic        tx_data;
  logic        tx_finish;
  logic        tx_clear_crc;
  logic        tx_acknowledge = 1'b0;
  logic        timeout_err;
  logic        overflow;
  logic [15:0] bytes_sent;

  always #5 clock = ~clock;

  uart_byte_feeder #(
    .DEPTH(DEPTH),
    .ACK_TIMEOUT(TO),
    .CLEAR_CRC_PER_BYTE(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .pause(pause),
    .err_clear(err_clear),
    .full(full),
    .empty(empty),
    .level(level),
    .busy(busy),
    .tx_send(tx_send),
    .tx_data(tx_data),
    .tx_finish(tx_finish),
    .tx_clear_crc(tx_clear_crc),
    .tx_acknowledge(tx_acknowledge),
    .timeout_err(timeout_err),
    .overflow(overflow),
    .bytes_sent(bytes_sent)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter acknowledge model: 0 = never, 1 = tied high, 2 = one-cycle pulse 3 cycles after a strobe.
  int         ack_mode = 1;
  logic [3:0] hist = 4'd0;
  always @(negedge clock) begin
    hist = {hist[2:0], tx_send | tx_finish};
    case (ack_mode)
      0:       tx_acknowledge = 1'b0;
      1:       tx_acknowledge = 1'b1;
      default: tx_acknowledge = hist[3];
    endcase
  end

  // Serial monitor: frames bytes from the strobes and checks bit stability and strobe spacing.
  logic       in_byte = 1'b0;
  int         bitcnt = 0;
  logic [7:0] rx_sh = 8'd0;
  logic [7:0] rx_q[$];
  int         n_start = 0;
  int         n_finish = 0;
  logic       prev_send = 1'b0;
  logic       prev_data = 1'b0;
  logic       hold_chk = 1'b0;
  logic       hold_val = 1'b0;
  int         mcyc = 0;
  int         last_send = 0;

  always @(negedge clock) begin
    mcyc++;
    if (!reset) begin
      in_byte  = 1'b0;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) chk("tx_data_hold_after_send", tx_data, hold_val);
      hold_chk = 1'b0;
      if (tx_clear_crc) in_byte = 1'b0;
      if (tx_send) begin
        chk("send_strobe_width", prev_send, 0);
        if (!in_byte) begin
          in_byte = 1'b1;
          bitcnt  = 0;
          n_start++;
        end else begin
          chk("tx_data_stable_into_send", tx_data, prev_data);
          if (ack_mode == 1) chk("send_to_send_gap", mcyc - last_send, 4);
          rx_sh    = {rx_sh[6:0], tx_data};
          bitcnt++;
          hold_chk = 1'b1;
          hold_val = tx_data;
        end
        last_send = mcyc;
      end
      if (tx_finish) begin
        n_finish++;
        chk("bits_per_byte", bitcnt, 8);
        if (ack_mode == 1) chk("send_to_finish_gap", mcyc - last_send, 3);
        rx_q.push_back(rx_sh);
        in_byte = 1'b0;
      end
    end
    prev_send = tx_send;
    prev_data = tx_data;
  end

  // seq holds the bits in transmission order, first bit sent in seq[7].
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
  } byte_vec_t;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       ec;
    logic [2:0] lvl;
    logic       fl;
    logic       em;
    logic       ov;
  } fifo_vec_t;

  byte_vec_t bv[10];
  fifo_vec_t fv[8];

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic at_pos();
    @(posedge clock);
    #1;
  endtask

  task automatic check_rx(input string name, input int vi);
    logic [7:0] got;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    else got = ~bv[vi].seq;
    chk(name, got, bv[vi].seq);
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    at_pos();
    wr_en   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int clr_k;
    int done_k;
    int s0;
    int f0;
    int wcnt;

    bv[0] = '{8'hA5, 8'b10100101};
    bv[1] = '{8'h00, 8'b00000000};
    bv[2] = '{8'h01, 8'b10000000};
    bv[3] = '{8'h80, 8'b00000001};
    bv[4] = '{8'hFF, 8'b11111111};
    bv[5] = '{8'h11, 8'b10001000};
    bv[6] = '{8'h22, 8'b01000100};
    bv[7] = '{8'h33, 8'b11001100};
    bv[8] = '{8'h44, 8'b00100010};
    bv[9] = '{8'hC3, 8'b11000011};

    fv[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    fv[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    fv[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
    fv[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    fv[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
    fv[5] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
    fv[6] = '{1'b1, 8'h66, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
    fv[7] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};

    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    pause     = 1'b0;
    err_clear = 1'b0;
    repeat (3) at_pos();
    at_neg();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_finish", tx_finish, 0);
    chk("rst_tx_clear_crc", tx_clear_crc, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bytes_sent", bytes_sent, 0);
    at_pos();
    reset = 1'b1;
    at_pos();

    // Single byte 0xA5 with acknowledge tied high: exact cycle timing.
    ack_mode = 1;
    rx_q.delete();
    s0 = n_start;
    f0 = n_finish;
    clr_k  = 0;
    done_k = 0;
    push_byte(8'hA5);
    for (int k = 1; k <= 100 && done_k == 0; k++) begin
      at_neg();
      if (k == 1) begin
        chk("A_pop_cycle_busy", busy, 0);
        chk("A_pop_cycle_level", level, 1);
      end
      if (k == 2) chk("A_level_after_pop", level, 0);
      if (tx_clear_crc && clr_k == 0) clr_k = k;
      if (bytes_sent != 16'd0) done_k = k;
    end
    chk("A_clear_crc_cycle", clr_k, 2);
    chk("A_byte_done_cycle", done_k, 41);
    chk("A_bytes_sent", bytes_sent, 1);
    chk("A_busy_after", busy, 0);
    chk("A_start_count", n_start - s0, 1);
    chk("A_finish_count", n_finish - f0, 1);
    chk("A_rx_count", rx_q.size(), 1);
    check_rx("A_rx_A5", 0);

    // Back-to-back bytes against the delayed-pulse acknowledge model.
    at_pos();
    ack_mode = 2;
    rx_q.delete();
    base = int'(bytes_sent);
    for (int i = 1; i <= 4; i++) push_byte(bv[i].data);
    for (int k = 0; k < 2000 && !((int'(bytes_sent) == base + 4) && !busy); k++) at_neg();
    chk("B_bytes_sent_delta", int'(bytes_sent) - base, 4);
    chk("B_busy_end", busy, 0);
    chk("B_empty_end", empty, 1);
    chk("B_rx_count", rx_q.size(), 4);
    check_rx("B_rx_00", 1);
    check_rx("B_rx_01", 2);
    check_rx("B_rx_80", 3);
    check_rx("B_rx_FF", 4);

    // FIFO fill while paused, overflow and err_clear priority.
    at_pos();
    ack_mode = 1;
    pause    = 1'b1;
    rx_q.delete();
    base = int'(bytes_sent);
    for (int r = 0; r < 8; r++) begin
      wr_en     = fv[r].wr;
      wr_data   = fv[r].d;
      err_clear = fv[r].ec;
      at_pos();
      wr_en     = 1'b0;
      err_clear = 1'b0;
      at_neg();
      chk("C_level", level, fv[r].lvl);
      chk("C_full", full, fv[r].fl);
      chk("C_empty", empty, fv[r].em);
      chk("C_overflow", overflow, fv[r].ov);
      chk("C_paused_busy", busy, 0);
    end
    pause = 1'b0;
    for (int k = 0; k < 400 && !((int'(bytes_sent) == base + 4) && !busy); k++) at_neg();
    chk("C_bytes_sent_delta", int'(bytes_sent) - base, 4);
    chk("C_empty_end", empty, 1);
    chk("C_rx_count", rx_q.size(), 4);
    check_rx("C_rx_11", 5);
    check_rx("C_rx_22", 6);
    check_rx("C_rx_33", 7);
    check_rx("C_rx_44", 8);

    // Acknowledge timeout: first byte aborted, next byte proceeds.
    at_pos();
    ack_mode = 0;
    at_pos();
    rx_q.delete();
    base = int'(bytes_sent);
    f0   = n_finish;
    push_byte(8'h5A);
    push_byte(8'hC3);
    for (int k = 0; k < 20 && !tx_send; k++) at_neg();
    chk("D_start_seen", tx_send, 1);
    wcnt = 0;
    for (int k = 0; k < 40; k++) begin
      at_neg();
      if (busy && !tx_send && !tx_finish && !tx_clear_crc) wcnt++;
      else break;
    end
    chk("D_wait_cycles", wcnt, TO);
    chk("D_idle_after_abort", busy, 0);
    chk("D_timeout_err", timeout_err, 1);
    chk("D_bytes_unchanged", int'(bytes_sent) - base, 0);
    at_neg();
    chk("D_next_byte_clear", tx_clear_crc, 1);
    ack_mode = 1;
    for (int k = 0; k < 100 && busy; k++) at_neg();
    chk("D_bytes_after_next", int'(bytes_sent) - base, 1);
    chk("D_finish_count", n_finish - f0, 1);
    chk("D_rx_count", rx_q.size(), 1);
    check_rx("D_rx_C3", 9);
    chk("D_timeout_sticky", timeout_err, 1);
    err_clear = 1'b1;
    at_pos();
    err_clear = 1'b0;
    at_neg();
    chk("D_timeout_cleared", timeout_err, 0);

    // Reset in the middle of bit 3.
    at_pos();
    ack_mode = 1;
    push_byte(8'hFF);
    push_byte(8'h0F);
    for (int k = 0; k < 80 && !(in_byte && bitcnt == 4); k++) at_neg();
    chk("E_reached_bit3", bitcnt, 4);
    f0    = n_finish;
    reset = 1'b0;
    at_pos();
    at_neg();
    chk("E_tx_send", tx_send, 0);
    chk("E_tx_data", tx_data, 0);
    chk("E_tx_finish", tx_finish, 0);
    chk("E_tx_clear_crc", tx_clear_crc, 0);
    chk("E_busy", busy, 0);
    chk("E_empty", empty, 1);
    chk("E_level", level, 0);
    chk("E_bytes_sent", bytes_sent, 0);
    reset = 1'b1;
    repeat (50) at_neg();
    chk("E_no_finish", n_finish - f0, 0);
    chk("E_stays_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
